// File: rtl/dcpu_sysbus.sv
// CPU system bus: IDLE/WAIT/ACK handshake in front of a word RAM and a compare-match timer.
// Request is captured in IDLE; RAM/register writes and read-data capture happen on the edge that enters ACK.
module dcpu_sysbus #(
  parameter int RAM_AW = 12,
  parameter int WAIT   = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  output logic        o_ack,
  output logic        o_int
);

  localparam bit NO_WAIT = (WAIT == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [15:0] addr_q;
  logic [15:0] dat_q;
  logic        we_q;

  logic [15:0] req_addr;
  logic [15:0] req_dat;
  logic        req_we;
  logic        go_ack;
  logic        xfer;
  logic        wr;
  logic        rd;
  logic        sel_ram;
  logic        sel_tcnt;
  logic        sel_tcmp;
  logic        sel_tctl;

  logic [15:0] mem [2**RAM_AW];
  logic [15:0] ram_rd;
  logic        ram_sel_q;
  logic [15:0] reg_rd;

  logic [15:0] tcnt;
  logic [15:0] tcmp;
  logic        en;
  logic        ie;
  logic        pend;
  logic        match;

  // With no wait states the transfer completes off the live bus, so the
  // access path must see i_addr/i_dat directly while still in IDLE.
  always_comb begin
    req_addr = addr_q;
    req_dat  = dat_q;
    req_we   = we_q;
    if (state == S_IDLE) begin
      req_addr = i_addr;
      req_dat  = i_dat;
      req_we   = i_we;
    end
  end

  assign go_ack = (state == S_IDLE && i_cs && NO_WAIT) ||
                  (state == S_WAIT && wait_cnt == 4'd0);
  assign xfer   = go_ack && !i_reset;
  assign wr     = xfer && req_we;
  assign rd     = xfer && !req_we;

  assign sel_ram  = (req_addr[15:RAM_AW] == '0);
  assign sel_tcnt = (req_addr == 16'hFF00);
  assign sel_tcmp = (req_addr == 16'hFF01);
  assign sel_tctl = (req_addr == 16'hFF02);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      o_ack    <= 1'b0;
      wait_cnt <= 4'd0;
      addr_q   <= 16'd0;
      dat_q    <= 16'd0;
      we_q     <= 1'b0;
    end else begin
      o_ack <= go_ack;
      case (state)
        S_IDLE: if (i_cs) begin
          addr_q <= i_addr;
          dat_q  <= i_dat;
          we_q   <= i_we;
          if (NO_WAIT) begin
            state <= S_ACK;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= 4'(WAIT - 1);
          end
        end
        S_WAIT: if (wait_cnt == 4'd0) state <= S_ACK;
                else wait_cnt <= wait_cnt - 4'd1;
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset so contents survive a mid-transfer reset.
  always_ff @(posedge i_clk) begin
    if (wr && sel_ram) mem[req_addr[RAM_AW-1:0]] <= req_dat;
    ram_rd <= mem[req_addr[RAM_AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      reg_rd    <= 16'd0;
      ram_sel_q <= 1'b0;
    end else begin
      reg_rd    <= 16'd0;
      ram_sel_q <= rd && sel_ram;
      if (rd) begin
        if (sel_tcnt) reg_rd <= tcnt;
        if (sel_tcmp) reg_rd <= tcmp;
        if (sel_tctl) reg_rd <= {pend, 13'd0, ie, en};
      end
    end
  end

  assign o_dat = (o_ack && ram_sel_q) ? ram_rd : reg_rd;

  assign match = en && (tcnt == tcmp);

  // Later assignments win: a CPU write to TCNT overrides the count/match load,
  // and a match sets PEND even when a write-1-to-clear lands on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tcnt <= 16'd0;
      tcmp <= 16'd0;
      en   <= 1'b0;
      ie   <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (en) tcnt <= match ? 16'd0 : tcnt + 16'd1;
      if (wr && sel_tcnt) tcnt <= req_dat;
      if (wr && sel_tcmp) tcmp <= req_dat;
      if (wr && sel_tctl) begin
        en <= req_dat[0];
        ie <= req_dat[1];
      end
      if (match) pend <= 1'b1;
      else if (wr && sel_tctl && req_dat[15]) pend <= 1'b0;
    end
  end

  assign o_int = pend & ie;

endmodule

// File: tb/tb_dcpu_sysbus.sv
// Bench for dcpu_sysbus: table of bus transfers scored through an expected-ack queue,
// plus hand sequences for back-to-back acks, timer match/wrap/collisions and mid-transfer reset.
module tb_dcpu_sysbus;
  localparam int WAIT_P = 1;

  logic        clk, rst;
  logic        cs, we;
  logic [15:0] addr, wdat, rdat;
  logic        ack, irq;
  logic        cs0, we0;
  logic [15:0] addr0, wdat0, rdat0;
  logic        ack0, irq0;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  bit mon_en = 0;

  typedef struct { logic [15:0] dat; int cyc; } exp_t;
  exp_t sb[$];

  typedef struct { logic we; logic [15:0] addr; logic [15:0] dat; logic [15:0] exp; } vec_t;
  vec_t vt[14];

  dcpu_sysbus #(.RAM_AW(12), .WAIT(WAIT_P)) dut (
    .i_clk(clk), .i_reset(rst), .i_cs(cs), .i_we(we), .i_addr(addr), .i_dat(wdat),
    .o_dat(rdat), .o_ack(ack), .o_int(irq)
  );

  dcpu_sysbus #(.RAM_AW(12), .WAIT(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_cs(cs0), .i_we(we0), .i_addr(addr0), .i_dat(wdat0),
    .o_dat(rdat0), .o_ack(ack0), .o_int(irq0)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer: idle cycle, raise cs, hold until ack seen, drop cs.
  task automatic bus(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] e);
    bit got;
    got = 0;
    tick();
    cs = 1; we = w; addr = a; wdat = d;
    sb.push_back('{e, cyc + WAIT_P + 1});
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ack === 1'b1) got = 1;
    end
    cs = 0; we = 0;
    if (!got) begin
      check("ack_timeout", 32'(got), 32'd1);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ack === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_dat", 32'(rdat), 32'(e.dat));
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check("idle_dat", 32'(rdat), 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int e_t, f_t, w_t;

    vt[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vt[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vt[2]  = '{1'b1, 16'h0000, 16'hA5A5, 16'h0000};
    vt[3]  = '{1'b1, 16'h0FFF, 16'h1234, 16'h0000};
    vt[4]  = '{1'b0, 16'h0FFF, 16'h0000, 16'h1234};
    vt[5]  = '{1'b1, 16'h1000, 16'h5555, 16'h0000};
    vt[6]  = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5};
    vt[7]  = '{1'b0, 16'h8000, 16'h0000, 16'h0000};
    vt[8]  = '{1'b1, 16'hFF10, 16'h7777, 16'h0000};
    vt[9]  = '{1'b0, 16'hFF00, 16'h0000, 16'h0000};
    vt[10] = '{1'b0, 16'hFF02, 16'h0000, 16'h0000};
    vt[11] = '{1'b1, 16'hFF01, 16'h00AB, 16'h0000};
    vt[12] = '{1'b0, 16'hFF01, 16'h0000, 16'h00AB};
    vt[13] = '{1'b0, 16'hFF03, 16'h0000, 16'h0000};

    rst = 1; cs = 0; we = 0; addr = 0; wdat = 0;
    cs0 = 0; we0 = 0; addr0 = 0; wdat0 = 0;
    repeat (3) tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", 32'(rdat), 32'd0);
    check("rst_int", 32'(irq), 32'd0);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_dat0", 32'(rdat0), 32'd0);
    check("rst_int0", 32'(irq0), 32'd0);
    rst = 0;
    mon_en = 1;

    // WAIT=0 instance with cs held: acks alternate, write then reads of the same word.
    cs0 = 1; we0 = 1; addr0 = 16'h0005; wdat0 = 16'h4242;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("w0_ack_pattern", 32'(ack0), 32'(i % 2));
      if (i % 2 == 1) check("w0_dat", 32'(rdat0), (i == 1) ? 32'h0 : 32'h4242);
      else check("w0_idle_dat", 32'(rdat0), 32'h0);
      if (i == 1) we0 = 0;
    end
    cs0 = 0;

    for (int i = 0; i < 14; i++) bus(vt[i].we, vt[i].addr, vt[i].dat, vt[i].exp);

    // Timer: TCMP=3 gives period 4; match edges are E+4k.
    bus(1, 16'hFF01, 16'h0003, 16'h0);
    bus(1, 16'hFF02, 16'h0003, 16'h0);
    e_t = cyc;
    check("int_at_enable", 32'(irq), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("int_seq", 32'(irq), (i >= 4) ? 32'd1 : 32'd0);
    end
    bus(0, 16'hFF00, 16'h0, 16'((cyc + 2 - e_t) % 4));
    bus(0, 16'hFF00, 16'h0, 16'((cyc + 2 - e_t) % 4));
    while ((cyc + 3 - e_t) % 4 != 0) tick();
    bus(1, 16'hFF02, 16'h8003, 16'h0);
    check("pend_set_wins", 32'(irq), 32'd1);
    if ((cyc + 3 - e_t) % 4 == 0) tick();
    bus(1, 16'hFF02, 16'h8003, 16'h0);
    check("pend_clear", 32'(irq), 32'd0);

    // Write to TCNT on a match edge: written value wins, PEND still set.
    bus(1, 16'hFF02, 16'h8000, 16'h0);
    check("int_masked", 32'(irq), 32'd0);
    bus(1, 16'hFF01, 16'h0002, 16'h0);
    bus(1, 16'hFF00, 16'h0000, 16'h0);
    bus(1, 16'hFF02, 16'h8003, 16'h0);
    f_t = cyc;
    check("pend_clear_idle", 32'(irq), 32'd0);
    while ((cyc + 3 - f_t) % 3 != 0) tick();
    bus(1, 16'hFF00, 16'h0005, 16'h0);
    w_t = cyc;
    check("match_under_write", 32'(irq), 32'd1);
    bus(0, 16'hFF00, 16'h0, 16'(5 + cyc + 2 - w_t));
    bus(0, 16'hFF02, 16'h0, 16'h8003);

    // Wrap through 0xFFFF with no match.
    bus(1, 16'hFF01, 16'h0100, 16'h0);
    bus(1, 16'hFF02, 16'h8003, 16'h0);
    bus(1, 16'hFF00, 16'hFFFC, 16'h0);
    w_t = cyc;
    bus(0, 16'hFF00, 16'h0, 16'(32'hFFFC + cyc + 2 - w_t));
    bus(0, 16'hFF00, 16'h0, 16'(32'hFFFC + cyc + 2 - w_t));
    check("no_pend_on_wrap", 32'(irq), 32'd0);

    // Reset during WAIT of a write: no ack, RAM kept, timer cleared.
    bus(1, 16'h0020, 16'h1111, 16'h0);
    tick();
    cs = 1; we = 1; addr = 16'h0020; wdat = 16'h2222;
    tick();
    rst = 1;
    tick();
    tick();
    cs = 0; we = 0; rst = 0;
    check("ack_after_reset", 32'(ack), 32'd0);
    check("int_after_reset", 32'(irq), 32'd0);
    bus(0, 16'hFF00, 16'h0, 16'h0000);
    bus(0, 16'hFF01, 16'h0, 16'h0000);
    bus(0, 16'hFF02, 16'h0, 16'h0000);
    bus(0, 16'h0020, 16'h0, 16'h1111);
    bus(0, 16'h0010, 16'h0, 16'hBEEF);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dcpu_sysbus.md
DCPU_SYSBUS -- requirements
Module: dcpu_sysbus

Interface
REQ-001 SHALL have parameter RAM_AW, default 12, meaning RAM address width (RAM depth 2^RAM_AW 16-bit words).
REQ-002 SHALL have parameter WAIT, default 1, meaning wait cycles inserted between request capture and acknowledge (0..15 legal).
REQ-003 SHALL have port i_clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port i_reset  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port i_cs  input  1  CPU bus request, held high by the CPU until acknowledged.
REQ-006 SHALL have port i_we  input  1  1 = write, 0 = read; qualified by i_cs.
REQ-007 SHALL have port i_addr  input  16  word address.
REQ-008 SHALL have port i_dat  input  16  write data from the CPU.
REQ-009 SHALL have port o_dat  output  16  read data; valid only while o_ack=1.
REQ-010 SHALL have port o_ack  output  1  one-cycle transfer-complete pulse, connected to the CPU's i_ack.
REQ-011 SHALL have port o_int  output  1  timer interrupt request, connected to the CPU's i_int.

Function
REQ-012 SHALL implement states IDLE, WAIT and ACK.
REQ-013 In IDLE with i_cs=1, SHALL capture i_addr, i_we and i_dat and go to WAIT, or go directly to ACK when WAIT=0.
REQ-014 In WAIT, SHALL count WAIT cycles, then go to ACK; i_cs, i_addr and i_dat changes are ignored after capture.
REQ-015 In ACK, SHALL drive o_ack=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-016 SHALL ack with o_ack high WAIT+1 cycles after the IDLE cycle that sampled i_cs=1.
REQ-017 SHALL NOT issue back-to-back acks; the mandatory IDLE cycle after ACK samples i_cs as a new request.
REQ-018 SHALL decode the address map as: 0x0000..2^RAM_AW-1 = RAM; 0xFF00 = TCNT; 0xFF01 = TCMP; 0xFF02 = TCTL; all other addresses unmapped.
REQ-019 SHALL make the RAM write, or the register write, take effect on the clock edge that enters ACK.
REQ-020 SHALL register read data so that o_dat carries the addressed word during the ACK cycle and 0 at all other times.
REQ-021 SHALL return 0 on reads of unmapped addresses, ignore writes to them, and still acknowledge them (no bus hang).
REQ-022 SHALL define TCTL as: bit0 = EN; bit1 = IE; bit15 = PEND (read-only except write-1-to-clear); other bits read 0.
REQ-023 When EN=1, SHALL increment TCNT every cycle; when TCNT==TCMP, SHALL load TCNT with 0 and set PEND, instead of incrementing.
REQ-024 SHALL wrap TCNT from 0xFFFF to 0x0000 without setting PEND unless TCMP matches.
REQ-025 SHALL drive o_int = PEND & IE combinationally from registers.
REQ-026 When a CPU write to TCNT coincides with a match or increment, SHALL let the written value win, and SHALL still set PEND if the pre-write value matched.
REQ-027 When a PEND clear coincides with a new match, SHALL leave PEND set (set wins).

Reset
REQ-028 On i_reset, SHALL set state to IDLE, o_ack to 0, o_dat to 0, and TCNT, TCMP and TCTL to 0, so that o_int=0.
REQ-029 On i_reset asserted mid-transfer (WAIT or ACK), SHALL abandon the transfer with no ack, and SHALL NOT alter RAM contents or clear them.

Verification
REQ-030 WAIT=1; write 0xBEEF to 0x0010, then read 0x0010 -> each ack arrives 2 cycles after the request is sampled, and the read returns o_dat=0xBEEF during ack.
REQ-031 WAIT=0; hold i_cs high continuously -> o_ack pattern is 1,0,1,0, with one IDLE cycle between acks.
REQ-032 Read 0x8000 (RAM_AW=12) and write 0xFF10 -> both acked, read o_dat=0x0000, no register changes.
REQ-033 TCMP=3, TCTL=0x0003 -> TCNT sequence 0,1,2,3,0; PEND and o_int rise the cycle TCNT goes 3->0; writing TCTL=0x8003 clears o_int.
REQ-034 Write TCNT=0x0005 in the cycle TCNT==TCMP=2 -> TCNT=0x0005 next cycle and PEND=1.
REQ-035 Assert i_reset during WAIT of a write to 0x0020 -> no ack, RAM[0x20] unchanged, all timer registers 0.
